// File: rtl/cmp_serial_acc.sv
// Bit-serial magnitude comparator: folds one 2-bit digit verdict per accepted beat,
// MSB digit first, into the eq/lt/gt result for two 2*NDIG-bit operands.
module cmp_serial_acc #(
    parameter int unsigned NDIG = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    input  logic dig_eq,
    input  logic dig_lt,
    input  logic dig_gt,
    output logic in_ready,
    output logic busy,
    output logic done,
    output logic eq,
    output logic lt,
    output logic gt,
    output logic err
);

    localparam int unsigned CNT_W = $clog2(NDIG + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             decided_q, decided_d;
    logic             lt_r_q, lt_r_d;
    logic             gt_r_q, gt_r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             err_q, err_d;

    logic             onehot_c;
    logic             accept_c;
    logic             dlt_c;
    logic             dgt_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            decided_q <= 1'b0;
            lt_r_q    <= 1'b0;
            gt_r_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            decided_q <= decided_d;
            lt_r_q    <= lt_r_d;
            gt_r_q    <= gt_r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
            err_q     <= err_d;
        end
    end

    // Malformed (non one-hot) digits count as equal and only raise err.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        decided_d = decided_q;
        lt_r_d    = lt_r_q;
        gt_r_d    = gt_r_q;
        done_d    = 1'b0;
        eq_d      = eq_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        err_d     = err_q;

        onehot_c = (dig_eq & ~dig_lt & ~dig_gt) |
                   (~dig_eq & dig_lt & ~dig_gt) |
                   (~dig_eq & ~dig_lt & dig_gt);
        accept_c = in_valid & (state_q == S_RUN) & ~start;
        dlt_c    = onehot_c & dig_lt;
        dgt_c    = onehot_c & dig_gt;

        if (start) begin
            state_d   = S_RUN;
            count_d   = '0;
            decided_d = 1'b0;
            lt_r_d    = 1'b0;
            gt_r_d    = 1'b0;
            eq_d      = 1'b0;
            lt_d      = 1'b0;
            gt_d      = 1'b0;
            err_d     = 1'b0;
        end else if (accept_c) begin
            count_d = count_q + CNT_W'(1);
            if (!onehot_c) begin
                err_d = 1'b1;
            end
            if (!decided_q && (dlt_c || dgt_c)) begin
                decided_d = 1'b1;
                lt_r_d    = dlt_c;
                gt_r_d    = dgt_c;
            end
            if (count_q == LAST_CNT) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                eq_d    = ~decided_d;
                lt_d    = lt_r_d;
                gt_d    = gt_r_d;
            end
        end

        busy_d = (state_d == S_RUN);
    end

    assign in_ready = busy_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign eq       = eq_q;
    assign lt       = lt_q;
    assign gt       = gt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_cmp_serial_acc.sv
// Directed bench for cmp_serial_acc: a queue-based operand-level model checked every
// cycle, plus hand-computed expectations per scenario.
module tb_cmp_serial_acc;

    localparam int unsigned NDIG = 4;
    localparam logic [2:0] D_EQ = 3'b100;
    localparam logic [2:0] D_LT = 3'b010;
    localparam logic [2:0] D_GT = 3'b001;

    logic clk;
    logic rst_n;
    logic start;
    logic in_valid;
    logic dig_eq;
    logic dig_lt;
    logic dig_gt;
    logic in_ready;
    logic busy;
    logic done;
    logic eq;
    logic lt;
    logic gt;
    logic err;

    int total;
    int bad;
    bit chk_en;

    cmp_serial_acc #(.NDIG(NDIG)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .dig_eq   (dig_eq),
        .dig_lt   (dig_lt),
        .dig_gt   (dig_gt),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .eq       (eq),
        .lt       (lt),
        .gt       (gt),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: digits accepted since start; verdict 0 none, 1 eq, 2 lt, 3 gt
    logic [2:0] m_dq[$];
    bit         m_busy;
    bit         m_done;
    bit         m_err;
    int         m_res;

    function automatic int verdict(input logic [2:0] q[$]);
        foreach (q[i]) begin
            if (q[i] == D_LT) return 2;
            if (q[i] == D_GT) return 3;
        end
        return 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_res  = 0;
            m_dq.delete();
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_busy = 1'b1;
                m_err  = 1'b0;
                m_res  = 0;
                m_dq.delete();
            end else if (m_busy && in_valid) begin
                m_dq.push_back({dig_eq, dig_lt, dig_gt});
                if (!({dig_eq, dig_lt, dig_gt} inside {D_EQ, D_LT, D_GT})) m_err = 1'b1;
                if (m_dq.size() == NDIG) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = verdict(m_dq);
                end
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     busy,     m_busy);
            check("in_ready", in_ready, m_busy);
            check("done",     done,     m_done);
            check("eq",       eq,       m_res == 1);
            check("lt",       lt,       m_res == 2);
            check("gt",       gt,       m_res == 3);
            check("err",      err,      m_err);
        end
    end

    function automatic logic [2:0] dig_of(input logic [7:0] x, input logic [7:0] y, input int i);
        logic [1:0] xd;
        logic [1:0] yd;
        xd = x[2*i +: 2];
        yd = y[2*i +: 2];
        if (xd == yd) return D_EQ;
        return (xd < yd) ? D_LT : D_GT;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        in_valid = 1'b0;
        {dig_eq, dig_lt, dig_gt} = 3'b000;
    endtask

    task automatic beat(input logic [2:0] d, input logic with_start);
        @(negedge clk);
        start = with_start;
        in_valid = 1'b1;
        {dig_eq, dig_lt, dig_gt} = d;
    endtask

    task automatic bubble();
        @(negedge clk);
        start = 1'b0;
        in_valid = 1'b0;
        {dig_eq, dig_lt, dig_gt} = 3'b000;
    endtask

    // Streams x vs y MSB digit first with gap bubbles between beats; returns at the
    // negedge one cycle after the last beat.
    task automatic compare_ops(input logic [7:0] x, input logic [7:0] y, input int gap);
        do_start();
        for (int i = NDIG - 1; i >= 0; i--) begin
            beat(dig_of(x, y, i), 1'b0);
            if (i > 0) repeat (gap) bubble();
        end
        bubble();
    endtask

    task automatic check_result(input string t, input logic e_eq, input logic e_lt,
                                input logic e_gt, input logic e_err);
        check({t, "_done"}, done, 1'b1);
        check({t, "_eq"},   eq,   e_eq);
        check({t, "_lt"},   lt,   e_lt);
        check({t, "_gt"},   gt,   e_gt);
        check({t, "_err"},  err,  e_err);
    endtask

    initial begin
        total = 0;
        bad = 0;
        chk_en = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        {dig_eq, dig_lt, dig_gt} = 3'b000;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_eq", eq, 1'b0);
        check("rst_err", err, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        bubble();

        // 1: B4 vs B4 back-to-back, then a stray beat in DONE must be ignored
        compare_ops(8'hB4, 8'hB4, 0);
        check_result("t1", 1'b1, 1'b0, 1'b0, 1'b0);
        beat(D_LT, 1'b0);
        bubble();
        check("t1_hold_eq", eq, 1'b1);
        check("t1_hold_done", done, 1'b0);

        // 2: 80 vs 7F -> gt on MSB digit
        compare_ops(8'h80, 8'h7F, 0);
        check_result("t2", 1'b0, 1'b0, 1'b1, 1'b0);

        // 3: 1C vs 1D with 2 bubbles between beats
        compare_ops(8'h1C, 8'h1D, 2);
        check_result("t3", 1'b0, 1'b1, 1'b0, 1'b0);

        // 4: restart with a gt digit on the start cycle; it must be dropped
        do_start();
        beat(D_EQ, 1'b0);
        beat(D_EQ, 1'b0);
        beat(D_GT, 1'b1);
        beat(D_EQ, 1'b0);
        beat(D_EQ, 1'b0);
        beat(D_EQ, 1'b0);
        bubble();
        check("t4_not_done", done, 1'b0);
        check("t4_busy", busy, 1'b1);
        beat(D_EQ, 1'b0);
        bubble();
        check_result("t4", 1'b1, 1'b0, 1'b0, 1'b0);

        // 6: malformed digit eq+lt counts as equal and raises err
        do_start();
        beat(D_EQ, 1'b0);
        beat(3'b110, 1'b0);
        beat(D_EQ, 1'b0);
        beat(D_EQ, 1'b0);
        bubble();
        check_result("t6", 1'b1, 1'b0, 1'b0, 1'b1);
        do_start();
        bubble();
        check("t6_err_clr", err, 1'b0);
        check("t6_busy", busy, 1'b1);

        // 5: async reset mid-RUN
        beat(D_LT, 1'b0);
        beat(D_EQ, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_ready", in_ready, 1'b0);
        check("t5_done", done, 1'b0);
        check("t5_lt", lt, 1'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        repeat (3) bubble();
        check("t5_idle_busy", busy, 1'b0);

        // model sanity after reset: a fresh compare still works
        compare_ops(8'h3F, 8'h40, 1);
        check_result("t7", 1'b0, 1'b1, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
